// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the pipeline control logic and the PC sequencer.
// The master drives redirect/stall/halt requests; the slave (sequencer) returns the PC state.
interface pc_sequencer_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] epc;
    logic        misalign;
    logic [31:0] instret;

    modport master (
        output stall, br_taken, br_target, jump, jump_target, trap, halt_req, resume,
        input  pc, pc_valid, epc, misalign, instret
    );

    modport slave (
        input  stall, br_taken, br_target, jump, jump_target, trap, halt_req, resume,
        output pc, pc_valid, epc, misalign, instret
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control with trap, stall, jump/branch
// redirect (misaligned targets divert to the trap vector) and a retired-PC counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst,
    pc_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_misalign;
    logic [31:0] r_instret;
    logic        r_pc_valid;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_epc_nxt;
    logic        w_misalign_nxt;
    logic [31:0] w_instret_nxt;
    logic [31:0] w_target;

    function automatic logic f_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // State and datapath registers; pc_valid is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_epc      <= 32'h0000_0000;
            r_misalign <= 1'b0;
            r_instret  <= 32'h0000_0000;
            r_pc_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_misalign <= w_misalign_nxt;
            r_instret  <= w_instret_nxt;
            r_pc_valid <= (w_state_nxt == ST_RUN);
        end
    end

    // Next-state logic; halt only takes effect when neither trap nor stall is active.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!bus.trap && !bus.stall && bus.halt_req) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Next PC / epc / misalign / instret in priority order: trap, stall, jump, branch, sequential.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_misalign_nxt = r_misalign;
        w_instret_nxt  = r_instret;
        w_target       = bus.jump ? bus.jump_target : bus.br_target;
        case (r_state)
            ST_RUN: begin
                if (bus.trap) begin
                    w_pc_nxt      = TRAP_VEC;
                    w_epc_nxt     = r_pc;
                    w_instret_nxt = r_instret + 32'd1;
                end else if (bus.stall) begin
                    w_pc_nxt      = r_pc;
                end else if (bus.jump || bus.br_taken) begin
                    if (f_misaligned(w_target)) begin
                        w_pc_nxt       = TRAP_VEC;
                        w_epc_nxt      = r_pc;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_pc_nxt       = w_target;
                    end
                    w_instret_nxt = r_instret + 32'd1;
                end else begin
                    w_pc_nxt      = r_pc + 32'd4;
                    w_instret_nxt = r_instret + 32'd1;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    assign bus.pc       = r_pc;
    assign bus.pc_valid = r_pc_valid;
    assign bus.epc      = r_epc;
    assign bus.misalign = r_misalign;
    assign bus.instret  = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: boot, redirect priority, stall/trap, misalign,
// halt/resume, PC wrap and reset from HALT, all against hand-computed values.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall       = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0000_0000;
        bus.jump        = 1'b0;
        bus.jump_target = 32'h0000_0000;
        bus.trap        = 1'b0;
        bus.halt_req    = 1'b0;
        bus.resume      = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        bus.jump        = 1'b1;
        bus.jump_target = tgt;
        step();
        bus.jump        = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_pc",       bus.pc,               32'h0);
        chk("rst_valid",    {31'd0, bus.pc_valid}, 32'h0);
        chk("rst_epc",      bus.epc,              32'h0);
        chk("rst_misalign", {31'd0, bus.misalign}, 32'h0);
        chk("rst_instret",  bus.instret,          32'h0);

        // Boot
        rst = 1'b0;
        chk("boot_c0_valid", {31'd0, bus.pc_valid}, 32'h0);
        step();
        chk("boot_c1_pc",    bus.pc,               32'h0);
        chk("boot_c1_valid", {31'd0, bus.pc_valid}, 32'h1);
        step();
        chk("boot_c2_pc",    bus.pc,               32'h4);
        chk("boot_c2_instr", bus.instret,          32'd1);
        step();
        chk("seq_pc8",       bus.pc,               32'h8);

        // Redirect: jump beats branch
        bus.jump = 1'b1; bus.jump_target = 32'h40;
        bus.br_taken = 1'b1; bus.br_target = 32'h80;
        step();
        idle();
        chk("redir_pc",      bus.pc,               32'h40);
        chk("redir_instr",   bus.instret,          32'd3);
        step();
        chk("redir_seq",     bus.pc,               32'h44);

        // Stall then stall+trap
        jump_to(32'h10);
        chk("pre_stall_pc",  bus.pc,               32'h10);
        bus.stall = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 32'h200;
        step();
        step();
        bus.jump = 1'b0;
        chk("stall_pc",      bus.pc,               32'h10);
        chk("stall_instr",   bus.instret,          32'd5);
        bus.trap = 1'b1;
        step();
        idle();
        chk("trap_pc",       bus.pc,               32'h100);
        chk("trap_epc",      bus.epc,              32'h10);
        chk("trap_instr",    bus.instret,          32'd6);

        // Misaligned branch target
        jump_to(32'h20);
        bus.br_taken = 1'b1; bus.br_target = 32'h33;
        step();
        idle();
        chk("mis_pc",        bus.pc,               32'h100);
        chk("mis_epc",       bus.epc,              32'h20);
        chk("mis_flag",      {31'd0, bus.misalign}, 32'h1);
        chk("mis_instr",     bus.instret,          32'd8);
        step();
        chk("mis_sticky",    {31'd0, bus.misalign}, 32'h1);
        chk("mis_seq",       bus.pc,               32'h104);

        // Halt / resume
        jump_to(32'h24);
        bus.halt_req = 1'b1;
        step();
        idle();
        chk("halt_pc",       bus.pc,               32'h28);
        chk("halt_valid",    {31'd0, bus.pc_valid}, 32'h0);
        chk("halt_instr",    bus.instret,          32'd11);
        bus.trap = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 32'h300;
        step();
        idle();
        chk("halt_trap_pc",  bus.pc,               32'h28);
        chk("halt_trap_epc", bus.epc,              32'h20);
        chk("halt_trap_ins", bus.instret,          32'd11);
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        chk("resume_pc",     bus.pc,               32'h28);
        chk("resume_valid",  {31'd0, bus.pc_valid}, 32'h1);
        step();
        chk("resume_seq",    bus.pc,               32'h2C);
        chk("resume_instr",  bus.instret,          32'd12);

        // Wrap
        jump_to(32'hFFFF_FFF8);
        step();
        chk("wrap_pre",      bus.pc,               32'hFFFF_FFFC);
        step();
        chk("wrap_pc",       bus.pc,               32'h0);
        chk("wrap_instr",    bus.instret,          32'd15);

        // Reset from HALT, coincident with trap
        bus.halt_req = 1'b1;
        step();
        idle();
        chk("halt2_valid",   {31'd0, bus.pc_valid}, 32'h0);
        chk("halt2_pc",      bus.pc,               32'h4);
        rst = 1'b1;
        bus.trap = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("rst2_pc",       bus.pc,               32'h0);
        chk("rst2_valid",    {31'd0, bus.pc_valid}, 32'h0);
        chk("rst2_misalign", {31'd0, bus.misalign}, 32'h0);
        chk("rst2_instret",  bus.instret,          32'h0);
        chk("rst2_epc",      bus.epc,              32'h0);
        step();
        chk("rst2_boot_pc",  bus.pc,               32'h0);
        chk("rst2_boot_val", {31'd0, bus.pc_valid}, 32'h1);
        step();
        chk("rst2_seq_pc",   bus.pc,               32'h4);
        chk("rst2_seq_ins",  bus.instret,          32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, giving the PC loaded on a trap.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the current PC this cycle.
REQ-006 The block SHALL have port br_taken, input, 1 bit: conditional branch resolved taken.
REQ-007 The block SHALL have port br_target, input, 32 bits: branch destination.
REQ-008 The block SHALL have port jump, input, 1 bit: unconditional jump (jal/jalr).
REQ-009 The block SHALL have port jump_target, input, 32 bits: jump destination.
REQ-010 The block SHALL have port trap, input, 1 bit: exception request.
REQ-011 The block SHALL have port halt_req, input, 1 bit: request to stop fetching (ebreak/debug).
REQ-012 The block SHALL have port resume, input, 1 bit: leave HALT.
REQ-013 The block SHALL have port pc, output, 32 bits: current fetch address, registered.
REQ-014 The block SHALL have port pc_valid, output, 1 bit: pc is a live fetch address this cycle.
REQ-015 The block SHALL have port epc, output, 32 bits: PC captured at the last trap or misaligned redirect.
REQ-016 The block SHALL have port misalign, output, 1 bit: sticky; set when a redirect target had bits[1:0] != 0.
REQ-017 The block SHALL have port instret, output, 32 bits: count of cycles in which pc advanced in RUN.

Function
REQ-018 The FSM SHALL have three states: BOOT, RUN and HALT, with the state encoding free.
REQ-019 BOOT SHALL last exactly one cycle; pc holds RESET_PC, pc_valid=0, and all inputs are ignored; the next state is RUN.
REQ-020 In RUN, pc_valid SHALL be 1, and the next pc SHALL be chosen by the priority order in REQ-021 to REQ-026.
REQ-021 Highest priority: on trap=1, next pc=TRAP_VEC and epc<=pc, regardless of stall.
REQ-022 Second priority: if stall=1, pc holds and br_taken, jump and halt_req are ignored; upstream re-asserts them after the stall.
REQ-023 Third priority: on jump=1, the target is jump_target; fourth priority: on br_taken=1, the target is br_target; if both are asserted, jump wins.
REQ-024 Redirect alignment: if the selected target has [1:0] != 0, next pc=TRAP_VEC, epc<=pc and misalign<=1, with no redirect to the bad target.
REQ-025 Otherwise in RUN, next pc SHALL be pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-026 On halt_req=1 in RUN with no trap and no stall, pc SHALL take its normal next value this cycle and the next state SHALL be HALT.
REQ-027 In HALT, pc SHALL hold, pc_valid=0, and trap, branch, jump and stall SHALL be ignored; resume=1 returns the FSM to RUN on the next cycle, with fetch continuing from the held pc.
REQ-028 instret SHALL increment by 1 in each RUN cycle in which pc takes a new value, including redirects and traps, and SHALL NOT increment on stall, in BOOT or in HALT; it wraps at 2^32.
REQ-029 misalign SHALL be cleared only by reset.
REQ-030 The outputs SHALL have no combinational path from inputs; all outputs are registered.

Reset
REQ-031 While rst=1, on each clock the block SHALL set pc=RESET_PC, state=BOOT, pc_valid=0, epc=0, misalign=0 and instret=0.
REQ-032 Reset SHALL override all other inputs, including in HALT and on the same cycle as trap.
REQ-033 Reset asserted mid-run SHALL abort any pending state; the first valid fetch after release SHALL be RESET_PC, one cycle after BOOT.

Verification
REQ-034 Boot: release rst with defaults -> cycle 0 pc=0, pc_valid=0; cycle 1 pc=0, pc_valid=1; cycle 2 pc=4; instret=1.
REQ-035 Redirect: at pc=8, apply jump=1 with jump_target=0x40 and br_taken=1 with br_target=0x80 -> next pc=0x40; then pc=0x44.
REQ-036 Stall vs trap: at pc=0x10, apply stall=1 for 2 cycles -> pc stays 0x10 and instret is unchanged; then stall=1 with trap=1 -> pc=0x100, epc=0x10.
REQ-037 Misalign: at pc=0x20, apply br_taken=1 with br_target=0x33 -> pc=0x100, epc=0x20, misalign=1, and misalign stays 1 afterwards.
REQ-038 Halt: halt_req at pc=0x24 -> pc=0x28 with pc_valid=0; trap is ignored while halted; resume -> pc_valid=1 at 0x28, then 0x2C.
REQ-039 Wrap and reset: run pc through 0xFFFF_FFFC -> next pc=0x0; assert rst in HALT -> pc=0, misalign=0, instret=0, and the FSM re-enters BOOT.
